// File: rtl/complex_stream_packer.sv
// rtl/complex_stream_packer.sv - packs signed re/im samples into {im,re} words behind a FIFO on a valid/ready stream
// Optional macro PACKER_ABS_EN: store |re|,|im| (saturating) after one extra input register stage.
module complex_stream_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 1024
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_i_valid,
  input  logic [15:0] s_i_re,
  input  logic [15:0] s_i_im,
  output logic        s_o_ready,
  output logic        m_o_data_valid,
  input  logic        m_i_data_ready,
  output logic [31:0] m_o_data,
  output logic        m_o_last,
  output logic [15:0] o_frame_count,
  output logic        o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(FRAME_LEN);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   ONE_C    = (AW+1)'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  logic          beat;
  logic [15:0]   beat_re;
  logic [15:0]   beat_im;

`ifdef PACKER_ABS_EN
  logic          beat_q;
  logic [15:0]   re_q;
  logic [15:0]   im_q;

  function automatic logic [15:0] abs16(input logic [15:0] v);
    if (v == 16'h8000)
      return 16'h7FFF;
    else if (v[15])
      return ~v + 16'd1;
    else
      return v;
  endfunction

  // Input register stage: all store/drop/index decisions see the registered beat
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      beat_q <= 1'b0;
      re_q   <= 16'd0;
      im_q   <= 16'd0;
    end else begin
      beat_q <= s_i_valid;
      re_q   <= abs16(s_i_re);
      im_q   <= abs16(s_i_im);
    end
  end

  assign beat    = beat_q;
  assign beat_re = re_q;
  assign beat_im = im_q;
`else
  assign beat    = s_i_valid;
  assign beat_re = s_i_re;
  assign beat_im = s_i_im;
`endif

  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   count;
  logic [IW-1:0] idx;
  logic          push;
  logic          pop;
  logic          last_bit;

  // Occupancy includes the word currently presented on the output registers
  assign s_o_ready   = (count < DEPTH_C);
  assign push        = beat && s_o_ready;
  assign pop         = m_o_data_valid && m_i_data_ready;
  assign last_bit    = (idx == LAST_IDX);
  assign rd_ptr_next = rd_ptr + AW'(1);

  // Storage array: written only on an accepted beat, contents need no reset
  always_ff @(posedge aclk) begin
    if (push)
      mem[wr_ptr] <= {last_bit, beat_im, beat_re};
  end

  // Control: pointers, occupancy, frame index, sticky overflow, output registers, frame counter
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      idx            <= '0;
      o_overflow     <= 1'b0;
      o_frame_count  <= 16'd0;
      m_o_data_valid <= 1'b0;
      m_o_data       <= 32'd0;
      m_o_last       <= 1'b0;
    end else begin
      // Index advances on every beat, stored or dropped, so frame alignment survives drops
      if (beat)
        idx <= last_bit ? '0 : idx + IW'(1);
      if (beat && !s_o_ready)
        o_overflow <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr_next;
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
      if (pop && m_o_last)
        o_frame_count <= o_frame_count + 16'd1;
      // Head view lags the store by one edge; entries pushed this edge are not yet eligible
      if (pop) begin
        m_o_data_valid <= (count > ONE_C);
        if (count > ONE_C)
          {m_o_last, m_o_data} <= mem[rd_ptr_next];
      end else begin
        m_o_data_valid <= (count != '0);
        if (count != '0)
          {m_o_last, m_o_data} <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_complex_stream_packer.sv
// tb/tb_complex_stream_packer.sv - directed self-checking bench for complex_stream_packer (FRAME_LEN=8, FIFO_DEPTH=16)
module tb_complex_stream_packer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_i_valid;
  logic [15:0] s_i_re;
  logic [15:0] s_i_im;
  logic        s_o_ready;
  logic        m_o_data_valid;
  logic        m_i_data_ready;
  logic [31:0] m_o_data;
  logic        m_o_last;
  logic [15:0] o_frame_count;
  logic        o_overflow;

  int total = 0;
  int bad   = 0;

  complex_stream_packer #(.FIFO_DEPTH(16), .FRAME_LEN(8)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_i_valid      (s_i_valid),
    .s_i_re         (s_i_re),
    .s_i_im         (s_i_im),
    .s_o_ready      (s_o_ready),
    .m_o_data_valid (m_o_data_valid),
    .m_i_data_ready (m_i_data_ready),
    .m_o_data       (m_o_data),
    .m_o_last       (m_o_last),
    .o_frame_count  (o_frame_count),
    .o_overflow     (o_overflow)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] re, input logic [15:0] im);
    s_i_valid = v;
    s_i_re    = re;
    s_i_im    = im;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    drive(1'b0, 16'd0, 16'd0);
    m_i_data_ready = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  initial begin
    aresetn = 1'b0;
    drive(1'b0, 16'd0, 16'd0);
    m_i_data_ready = 1'b0;

    // Reset state
    do_reset();
    check("rst_valid", m_o_data_valid, 0);
    check("rst_data", m_o_data, 0);
    check("rst_last", m_o_last, 0);
    check("rst_fc", o_frame_count, 0);
    check("rst_ov", o_overflow, 0);
    check("rst_ready", s_o_ready, 1);

    // Packing of four signed samples, one-cycle latency
    m_i_data_ready = 1'b1;
    drive(1'b1, 16'h0001, 16'h0002);
    tick();
    check("pack_latency", m_o_data_valid, 0);
    drive(1'b1, 16'hFFFF, 16'hFFFE);
    tick();
    check("pack_v0", m_o_data_valid, 1);
    check("pack_w0", m_o_data, 32'h00020001);
    drive(1'b1, 16'h0064, 16'hFF9C);
    tick();
    check("pack_w1", m_o_data, 32'hFFFEFFFF);
    drive(1'b1, 16'h7FFF, 16'h8000);
    tick();
    check("pack_w2", m_o_data, 32'hFF9C0064);
    drive(1'b0, 16'd0, 16'd0);
    tick();
    check("pack_w3", m_o_data, 32'h80007FFF);
    check("pack_v3", m_o_data_valid, 1);
    tick();
    check("pack_empty", m_o_data_valid, 0);

    // 24 continuous beats, frame length 8
    do_reset();
    m_i_data_ready = 1'b1;
    for (int i = 0; i <= 24; i++) begin
      if (i < 24) drive(1'b1, 16'(i), 16'(16'h0100 + i));
      else        drive(1'b0, 16'd0, 16'd0);
      tick();
      if (i >= 1) begin
        check($sformatf("frm_data%0d", i - 1), m_o_data, {16'(16'h0100 + i - 1), 16'(i - 1)});
        check($sformatf("frm_last%0d", i - 1), m_o_last, ((i - 1) % 8 == 7) ? 1 : 0);
      end
    end
    drive(1'b0, 16'd0, 16'd0);
    tick();
    check("frm_count", o_frame_count, 3);
    check("frm_empty", m_o_data_valid, 0);

    // Overflow: 20 beats into a stalled 16-deep FIFO
    do_reset();
    m_i_data_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 16'(i + 1), 16'd0);
      tick();
      if (i == 15) begin
        check("ovf_ready_full", s_o_ready, 0);
        check("ovf_not_yet", o_overflow, 0);
      end
    end
    drive(1'b0, 16'd0, 16'd0);
    check("ovf_sticky", o_overflow, 1);
    m_i_data_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      check($sformatf("ovf_valid%0d", j), m_o_data_valid, 1);
      check($sformatf("ovf_data%0d", j), m_o_data, 32'(j + 1));
      tick();
    end
    check("ovf_drained", m_o_data_valid, 0);
    check("ovf_fc", o_frame_count, 2);
    // Index advanced 20 -> sits at 4; the fourth following beat closes the frame
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) drive(1'b1, 16'(16'h0040 + k), 16'd0);
      else       drive(1'b0, 16'd0, 16'd0);
      tick();
      if (k >= 1) begin
        check($sformatf("idx_data%0d", k - 1), m_o_data, 32'(16'h0040 + k - 1));
        check($sformatf("idx_last%0d", k - 1), m_o_last, (k == 4) ? 1 : 0);
      end
    end

    // Backpressure pattern 1,0,0,1
    do_reset();
    m_i_data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(16'h00A0 + i), 16'd0);
      tick();
    end
    drive(1'b0, 16'd0, 16'd0);
    check("bp_head", m_o_data, 32'h000000A0);
    m_i_data_ready = 1'b1; tick();
    check("bp_r1", m_o_data, 32'h000000A1);
    m_i_data_ready = 1'b0; tick();
    check("bp_hold1", m_o_data, 32'h000000A1);
    check("bp_hold1_v", m_o_data_valid, 1);
    m_i_data_ready = 1'b0; tick();
    check("bp_hold2", m_o_data, 32'h000000A1);
    m_i_data_ready = 1'b1; tick();
    check("bp_r2", m_o_data, 32'h000000A2);
    tick();
    check("bp_empty", m_o_data_valid, 0);

    // Full FIFO: beat and pop in the same cycle -> beat dropped
    do_reset();
    m_i_data_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 16'(i), 16'd0);
      tick();
    end
    check("full_ov0", o_overflow, 0);
    check("full_ready0", s_o_ready, 0);
    drive(1'b1, 16'h0099, 16'd0);
    m_i_data_ready = 1'b1;
    tick();
    drive(1'b0, 16'd0, 16'd0);
    check("full_ov1", o_overflow, 1);
    check("full_ready15", s_o_ready, 1);
    for (int j = 1; j < 16; j++) begin
      check($sformatf("full_data%0d", j), m_o_data, 32'(j));
      check($sformatf("full_last%0d", j), m_o_last, (j == 7 || j == 15) ? 1 : 0);
      tick();
    end
    check("full_drained", m_o_data_valid, 0);
    check("full_fc", o_frame_count, 2);

    // Mid-frame reset with 5 words buffered
    m_i_data_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'(16'h0050 + i), 16'd0);
      tick();
    end
    drive(1'b0, 16'd0, 16'd0);
    check("mid_buffered", m_o_data_valid, 1);
    aresetn = 1'b0;
    tick();
    check("mid_valid", m_o_data_valid, 0);
    check("mid_fc", o_frame_count, 0);
    check("mid_ov", o_overflow, 0);
    check("mid_ready", s_o_ready, 1);
    aresetn = 1'b1;
    m_i_data_ready = 1'b1;
    tick();
    check("mid_stays_empty", m_o_data_valid, 0);
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) drive(1'b1, 16'(16'h0060 + k), 16'd0);
      else       drive(1'b0, 16'd0, 16'd0);
      tick();
      if (k >= 1) begin
        check($sformatf("mid_data%0d", k - 1), m_o_data, 32'(16'h0060 + k - 1));
        check($sformatf("mid_last%0d", k - 1), m_o_last, (k == 8) ? 1 : 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/complex_stream_packer.md
Name: complex_stream_packer

Overview:
- Transmit-side companion to the magnitude stage: accepts FFT output as separate signed 16-bit real/imag samples.
- Packs each sample into one 32-bit word, imag in [31:16] and real in [15:0].
- Buffers words in a small FIFO and drives them on a valid/ready master stream that feeds the magnitude stage's slave input.
- Marks frame boundaries with a last flag and counts completed frames.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 2.
- FRAME_LEN, 1024, samples per FFT frame; minimum 2.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- s_i_valid  in  1  FFT sample strobe; FFT core cannot stall
- s_i_re  in  16  signed real part
- s_i_im  in  16  signed imag part
- s_o_ready  out  1  FIFO has room (status only)
- m_o_data_valid  out  1  output word valid
- m_i_data_ready  in  1  downstream accepts word
- m_o_data  out  32  {imag, real}
- m_o_last  out  1  word is last sample of its frame
- o_frame_count  out  16  frames fully transmitted, wraps at 65535->0
- o_overflow  out  1  sticky: a sample was dropped

Interface rule: reset is aresetn, synchronous, active-low; clock is aclk.

Behaviour:
- Reset (aresetn low at a rising edge) clears everything, overriding any in-flight operation:
  - m_o_data_valid=0, m_o_data=0, m_o_last=0.
  - o_frame_count=0, o_overflow=0, s_o_ready=1.
  - FIFO emptied, sample index=0.
  - FIFO contents are don't-care.
- Beat: any cycle with s_i_valid=1.
  - Sample index (0..FRAME_LEN-1) advances on every beat, stored or dropped, and wraps FRAME_LEN-1 -> 0. Frame alignment survives drops.
  - last bit = (index == FRAME_LEN-1).
- Store:
  - A beat is stored when FIFO occupancy < FIFO_DEPTH, evaluated before this cycle's pop.
  - Entry = {last, s_i_im, s_i_re}, 33 bits.
  - s_o_ready = (occupancy < FIFO_DEPTH), combinational from registered occupancy.
- Drop:
  - A beat arriving when the FIFO is full is discarded and o_overflow is set.
  - o_overflow stays set until reset.
  - A pop in the same cycle does not rescue the beat.
- Output:
  - m_o_data_valid = FIFO not empty; m_o_data/m_o_last present the head entry.
  - All three are registered outputs.
  - Latency: a word stored at edge k is visible with m_o_data_valid=1 after edge k+1 when the FIFO was empty.
- Pop: occurs when m_o_data_valid && m_i_data_ready.
  - Back-to-back pops sustain one word per cycle.
  - m_o_data and m_o_last must hold stable while valid && !ready.
- Simultaneous push and pop on a non-full FIFO: occupancy unchanged, ordering preserved.
- Frame count: o_frame_count increments by 1 on each pop with m_o_last=1.
- Pointers: read/write pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with log2(FIFO_DEPTH)+1 bits.
- Arithmetic: no arithmetic on data in the default build; bits pass through unchanged.

Optional Feature:
- Macro: PACKER_ABS_EN.
- Defined:
  - Each component is replaced by its absolute value before storing (two's-complement negate when bit 15 = 1).
  - -32768 (16'h8000) saturates to 32767 (16'h7FFF).
  - Adds one register stage on the input side: s_i_valid/re/im are registered once before the store logic, so input-to-output latency grows by one cycle.
  - Overflow and index rules apply at the registered stage.
- Undefined: components pass unmodified, no extra stage.

Test Plan:
- Reset then stream 4 beats re/im = (1,2),(−1,−2),(100,−100),(0x7FFF,0x8000) with m_i_data_ready=1 -> words 0x00020001, 0xFFFEFFFF, 0xFF9C0064, 0x80007FFF in order, first valid 1 cycle after first store.
  - With PACKER_ABS_EN: 0x00020001, 0x00020001, 0x00640064, 0x7FFF7FFF, one cycle later.
- FRAME_LEN=8, stream 24 continuous beats with ready=1 -> m_o_last high on words 8, 16, 24 only; o_frame_count reads 3.
- FIFO_DEPTH=16, ready=0, 20 beats -> 16 stored, s_o_ready=0 after 16th, o_overflow=1. Then ready=1 -> exactly the first 16 samples emerge in order; sample index still advanced 20.
- Backpressure: toggle m_i_data_ready 1,0,0,1 while valid -> m_o_data stable during the 0 cycles, no duplicate or skipped word.
- Full FIFO with s_i_valid=1 and pop in the same cycle -> new beat dropped, o_overflow=1, occupancy 15.
- Assert aresetn=0 mid-frame with 5 words buffered -> next cycle m_o_data_valid=0, o_frame_count=0, o_overflow=0. After release, the first new beat has index 0.
